// File: rtl/bus_grant_ctrl_pkg.sv
// Shared definitions for the system bus arbiter: master indices, one-hot
// grant constants, the arbiter state type and the default watchdog length.
package bus_pkg;

  localparam int NUM_M = 4;

  localparam logic [1:0] M_TIC = 2'd0;
  localparam logic [1:0] M_ONE = 2'd1;
  localparam logic [1:0] M_TWO = 2'd2;
  localparam logic [1:0] M_ARM = 2'd3;

  localparam logic [3:0] TIC = 4'b0001;
  localparam logic [3:0] ONE = 4'b0010;
  localparam logic [3:0] TWO = 4'b0100;
  localparam logic [3:0] ARM = 4'b1000;

  localparam int DEF_TIMEOUT_CYCLES = 256;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY     = 2'd1,
    HANDOVER = 2'd2
  } state_t;

  // Encode a one-hot master vector into its index (zero vector maps to TIC).
  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = M_TIC;
    if (oh[1]) idx = M_ONE;
    if (oh[2]) idx = M_TWO;
    if (oh[3]) idx = M_ARM;
    return idx;
  endfunction

endpackage

// File: rtl/bus_grant_ctrl_if.sv
// Arbiter <-> bus signal bundle.
// Handshake: a master raises i_req[m] (level) and holds it until o_gnt[m]
// is seen high; o_gnt is the "ready" and stays high for the whole
// transaction, which ends on i_done (ignored while i_wait is high) or when
// the owner drops its request. o_gnt is never multi-hot.
// Optional statistics ports exist only when BUS_GRANT_STATS_EN is defined.
interface bus_grant_ctrl_if;
  import bus_pkg::*;

  logic [3:0] i_req;
  logic [3:0] i_lock;
  logic       i_done;
  logic       i_wait;
  logic       i_pause;
  logic [3:0] o_gnt;
  logic [1:0] o_owner;
  logic       o_busy;
  logic       o_timeout;
  state_t     o_dbg_state;
`ifdef BUS_GRANT_STATS_EN
  logic [63:0] o_gnt_cnt;
  logic [7:0]  o_to_cnt;
`endif

  // Arbiter side.
  modport slave (
    input  i_req, i_lock, i_done, i_wait, i_pause,
`ifdef BUS_GRANT_STATS_EN
    output o_gnt_cnt, o_to_cnt,
`endif
    output o_gnt, o_owner, o_busy, o_timeout, o_dbg_state
  );

  // Bus / master side.
  modport master (
    output i_req, i_lock, i_done, i_wait, i_pause,
`ifdef BUS_GRANT_STATS_EN
    input  o_gnt_cnt, o_to_cnt,
`endif
    input  o_gnt, o_owner, o_busy, o_timeout, o_dbg_state
  );

endinterface

// File: rtl/bus_grant_ctrl_rr_pick3.sv
// Combinational round-robin picker over requesters 1..3. Searches upward
// from rr_ptr_i+1, wrapping 3->1; a pointer of 0 behaves like 3.
module rr_pick3 (
  input  logic [3:1] req_i,
  input  logic [1:0] rr_ptr_i,
  output logic [3:1] gnt_o,
  output logic       valid_o
);

  logic [1:0] cand;

  // First requester found after the pointer wins.
  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    cand    = 2'd1;
    for (int k = 1; k <= 3; k++) begin
      cand = 2'(((int'(rr_ptr_i) + k - 1) % 3) + 1);
      if (!valid_o && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_grant_ctrl.sv
// Sequencing arbiter for the four-master system bus (TIC, ONE, TWO, ARM).
// TIC has absolute priority, ONE..ARM share the bus round-robin. Supports
// per-master lock, slave wait, global pause and a watchdog that revokes a
// hung grant. Optional grant/timeout counters: BUS_GRANT_STATS_EN.
module bus_grant_ctrl
  import bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  bus_grant_ctrl_if.slave  bus
);

  state_t           state_q;
  logic [3:0]       gnt_q;
  logic [1:0]       owner_q;
  logic             busy_q;
  logic             timeout_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       rr_ptr_q;

  logic [3:1]       rr_gnt;
  logic             rr_valid;
  logic [3:0]       win_gnt;
  logic [1:0]       win_idx;
  logic             own_req;
  logic             own_lock;
  logic             release_ev;
  logic             keep_ev;
  logic             to_hit;

  rr_pick3 u_rr_pick3 (
    .req_i    (bus.i_req[3:1]),
    .rr_ptr_i (rr_ptr_q),
    .gnt_o    (rr_gnt),
    .valid_o  (rr_valid)
  );

  // Winner selection and BUSY-state release/timeout events.
  always_comb begin
    win_gnt = '0;
    if (bus.i_req[M_TIC]) win_gnt = TIC;
    else if (rr_valid)    win_gnt = {rr_gnt, 1'b0};
    win_idx    = onehot_to_idx(win_gnt);
    own_req    = bus.i_req[owner_q];
    own_lock   = bus.i_lock[owner_q];
    // done during a slave wait does not end the transaction
    release_ev = (bus.i_done && !bus.i_wait) || !own_req;
    keep_ev    = release_ev && own_lock && own_req;
    // release on the same cycle takes precedence over the watchdog
    to_hit     = !release_ev && !bus.i_wait &&
                 (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  // Arbiter FSM with registered outputs and watchdog counter.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      owner_q   <= M_TIC;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      rr_ptr_q  <= M_ARM;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!bus.i_pause && (win_gnt != 4'b0)) begin
            state_q <= BUSY;
            gnt_q   <= win_gnt;
            owner_q <= win_idx;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            if (win_idx != M_TIC) rr_ptr_q <= win_idx;
          end
        end
        BUSY: begin
          if (release_ev) begin
            if (keep_ev) begin
              // locked back-to-back transfer: same owner, fresh watchdog
              cnt_q <= '0;
            end else begin
              state_q <= HANDOVER;
              gnt_q   <= '0;
              busy_q  <= 1'b0;
            end
          end else if (to_hit) begin
            state_q   <= HANDOVER;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
            if (owner_q != M_TIC) rr_ptr_q <= owner_q;
          end else if (!bus.i_wait) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HANDOVER: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_gnt       = gnt_q;
  assign bus.o_owner     = owner_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_timeout   = timeout_q;
  assign bus.o_dbg_state = state_q;

`ifdef BUS_GRANT_STATS_EN
  logic [3:0][15:0] gnt_cnt_q;
  logic [7:0]       to_cnt_q;
  logic             new_grant;

  assign new_grant = (state_q == IDLE) && !bus.i_pause && (win_gnt != 4'b0);

  // Saturating per-master grant counters and timeout counter.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      gnt_cnt_q <= '0;
      to_cnt_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_M; i++) begin
        if (new_grant && win_gnt[i] && (gnt_cnt_q[i] != 16'hFFFF))
          gnt_cnt_q[i] <= gnt_cnt_q[i] + 16'd1;
      end
      if ((state_q == BUSY) && to_hit && (to_cnt_q != 8'hFF))
        to_cnt_q <= to_cnt_q + 8'd1;
    end
  end

  assign bus.o_gnt_cnt = gnt_cnt_q;
  assign bus.o_to_cnt  = to_cnt_q;
`endif

endmodule
